// File: rtl/vga_timing_pattern_gen.sv
// VGA sync/DE/coordinate generator with a pixel clock-enable divider and a
// frame-latched RGB test pattern (solid, colour bars, checkerboard, grey ramp).
module vga_timing_pattern_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0,
  parameter int COLOR_W  = 4,
  parameter int CHK_LOG2 = 5,
  parameter logic [3*COLOR_W-1:0] SOLID_RGB = 12'hF00,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pat_mode,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic [HW-1:0]      x,
  output logic [VW-1:0]      y,
  output logic               pix_strb,
  output logic               line_start,
  output logic               frame_start,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int GW    = $clog2(H_ACTIVE);
  localparam int G_SHR = (GW >= COLOR_W) ? GW - COLOR_W : 0;
  localparam int G_SHL = (GW >= COLOR_W) ? 0 : COLOR_W - GW;

  localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  localparam logic [31:0] H_ACT32 = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT32 = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEG  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END  = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END  = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]      div_cnt;
  logic [HW-1:0]      hc;
  logic [VW-1:0]      vc;
  logic [BW-1:0]      bar_cnt;
  logic [2:0]         bar_idx;
  logic [1:0]         mode_q;

  logic               ce;
  logic               at_origin;
  logic [1:0]         mode_eff;
  logic [31:0]        hc_ext;
  logic [31:0]        vc_ext;
  logic               hs_act;
  logic               vs_act;
  logic               de_nxt;
  logic [COLOR_W-1:0] grey;
  logic [COLOR_W-1:0] r_nxt;
  logic [COLOR_W-1:0] g_nxt;
  logic [COLOR_W-1:0] b_nxt;

  assign ce        = (div_cnt == D_LAST);
  assign at_origin = (div_cnt == '0) && (hc == '0) && (vc == '0);
  // The origin sample feeds pixel (0,0) directly, then mode_q holds it.
  assign mode_eff  = at_origin ? pat_mode : mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      hc      <= '0;
      vc      <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
      mode_q  <= '0;
    end else begin
      if (at_origin) mode_q <= pat_mode;
      div_cnt <= ce ? '0 : div_cnt + 1'b1;
      if (ce) begin
        if (hc == H_LAST) begin
          hc      <= '0;
          bar_cnt <= '0;
          bar_idx <= '0;
          vc      <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
          hc <= hc + 1'b1;
          // Bar index tracks hc/BAR_W and sticks at 7 (black) past the last bar.
          if (bar_cnt == BAR_LAST) begin
            bar_cnt <= '0;
            if (bar_idx != 3'd7) bar_idx <= bar_idx + 1'b1;
          end else begin
            bar_cnt <= bar_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    hc_ext = 32'(hc);
    vc_ext = 32'(vc);
    hs_act = (hc_ext >= HS_BEG) && (hc_ext < HS_END);
    vs_act = (vc_ext >= VS_BEG) && (vc_ext < VS_END);
    de_nxt = (hc_ext < H_ACT32) && (vc_ext < V_ACT32);
    grey   = COLOR_W'((hc_ext >> G_SHR) << G_SHL);
    r_nxt  = '0;
    g_nxt  = '0;
    b_nxt  = '0;
    if (de_nxt) begin
      case (mode_eff)
        2'd0: {r_nxt, g_nxt, b_nxt} = SOLID_RGB;
        2'd1: begin
          r_nxt = {COLOR_W{~bar_idx[1]}};
          g_nxt = {COLOR_W{~bar_idx[2]}};
          b_nxt = {COLOR_W{~bar_idx[0]}};
        end
        2'd2: begin
          r_nxt = {COLOR_W{~(hc_ext[CHK_LOG2] ^ vc_ext[CHK_LOG2])}};
          g_nxt = r_nxt;
          b_nxt = r_nxt;
        end
        default: begin
          r_nxt = grey;
          g_nxt = grey;
          b_nxt = grey;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      pix_strb    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      h_sync      <= hs_act ? H_POL : ~H_POL;
      v_sync      <= vs_act ? V_POL : ~V_POL;
      de          <= de_nxt;
      x           <= hc;
      y           <= vc;
      pix_strb    <= (div_cnt == '0);
      line_start  <= (div_cnt == '0) && (hc == '0);
      frame_start <= at_origin;
      r           <= r_nxt;
      g           <= g_nxt;
      b           <= b_nxt;
    end
  end

endmodule
